highpass_ch_arbiter: RTL and testbench
======================================

# highpass_ch_arbiter

Four-channel scheduler for the shared high-pass FIR. Each hydrophone/ADC channel delivers its own 24-bit AXI-Stream. This block buffers one sample per channel and grants the single FIR input port to one channel per beat. It tags each beat with its channel index on tuser and marks channel 3 with tlast. It sits directly upstream of the FIR, whose per-channel delay-line bank is selected by tuser.

## Interface
Parameters:
- DW, 24, sample width (signed)
- NCH, 4, channel count (fixed; tuser is 2 bits)

Ports:
- s_axis_aclk  in  1  clock
- s_axis_arstn  in  1  reset; one clock, reset is asynchronous and active-low
- ch_en  in  4  per-channel enable, sampled every cycle
- s_axis_tdata  in  NCH*DW  channel i in bits [i*DW +: DW]
- s_axis_tvalid  in  NCH  per-channel valid
- s_axis_tready  out  NCH  per-channel ready
- m_axis_tdata  out  DW  granted sample, to FIR
- m_axis_tvalid  out  1  output valid, registered
- m_axis_tready  in  1  FIR ready
- m_axis_tuser  out  2  channel index of current beat
- m_axis_tlast  out  1  high when m_axis_tuser == 3
- frame_cnt  out  16  count of accepted tlast beats, wraps at 0xFFFF -> 0

## Operation
- Each channel has a one-entry holding register: hold_d[i] plus hold_v[i].
- Input handshake i occurs when s_axis_tvalid[i] & s_axis_tready[i]. It loads hold_d[i] and sets hold_v[i].
- s_axis_tready[i] = !ch_en[i] | !hold_v[i] | take[i]. take[i] means channel i's held sample moves to the output register this cycle. This gives a combinational path from m_axis_tready and supports 1 beat/clk per channel.
- Disabled channel (ch_en[i]=0):
  - hold_v[i] clears on the next edge.
  - Inputs are accepted and discarded.
  - The channel is never granted.
- The output register loads when load = (!m_axis_tvalid | m_axis_tready) & |elig. elig[i] = hold_v[i] & ch_en[i].
- Round-robin arbitration (default):
  - Priority starts at ptr+1 and wraps mod 4.
  - ptr updates to the granted index on each load.
  - ptr resets to 3, so channel 0 has first priority.
- On load: m_axis_tdata<=hold_d[g], m_axis_tuser<=g, m_axis_tlast<=(g==3), m_axis_tvalid<=1.
- m_axis_tvalid clears on handshake when there is no simultaneous load.
- Output fields stay stable while m_axis_tvalid & !m_axis_tready.
- frame_cnt increments on every output handshake with m_axis_tlast=1.
- Data passes through unmodified: no arithmetic and no width change.

## Timing
- Reset values:
  - s_axis_tready = 0 during reset, then follows the equation above.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0.
  - frame_cnt=0, hold_v=0, ptr=3, next_ch=0.
- Latency: input accepted on edge E gives m_axis_tvalid high after edge E+1, provided the output slot is free and the channel wins arbitration.
- Throughput: 1 output beat/clk when m_axis_tready is held high.
- Worst-case wait in round-robin: 3 beats.
- Simultaneous take[i] and new input on channel i: hold_d[i] is replaced and hold_v[i] stays 1.
- ch_en[i] falling while hold_v[i]=1: the sample is dropped. A beat already in the output register still completes.
- Reset asserted mid-beat: all state clears asynchronously, and pending samples are lost.

## Configuration
- HIGHPASS_ARB_STRICT_ORDER_EN defined:
  - Only channel next_ch is eligible.
  - next_ch advances to the next enabled channel after each load, in cyclic order 0..3.
  - When ch_en is all zero, next_ch holds.
  - If next_ch is disabled, it advances to the next enabled channel on the next edge without granting.
  - Guarantees tuser order 0,1,2,3 per frame, and the FIR's per-channel sequence cannot reorder.
- Undefined: work-conserving round-robin as described above. ptr is used and next_ch is absent.

## Test plan
- Reset, then all four channels present one sample each (0x000001..0x000004) in the same cycle, m_axis_tready=1 -> four consecutive beats with tuser 0,1,2,3 and tlast only on the 4th; frame_cnt=1.
- Only channel 2 streams 10 back-to-back samples -> 10 consecutive output beats, tuser=2, tlast=0, full 1 beat/clk, s_axis_tready[2] never low.
- m_axis_tready low for 5 cycles with all holding registers full -> m_axis_tdata/tuser stable and s_axis_tready=0000. On release, the 4 held beats drain in round-robin order, then 0x7FFFFF and 0x800000 pass through bit-exact.
- ch_en=1011 with all channels streaming -> channel 2 is never granted, s_axis_tready[2]=1 with data discarded, and the beat sequence is 0,1,3 repeating.
- Strict build: channel 1 valid for 4 cycles before channel 0 -> no output until channel 0 arrives, then order 0,1,2,3.
- Reset asserted while 3 holding registers are full and m_axis_tvalid=1 -> m_axis_tvalid=0 immediately. After release, no stale beats appear, ptr=3, and frame_cnt=0.

Source files
------------

// File: rtl/highpass_ch_arbiter_if.sv
// highpass_ch_arbiter_if
//   Stream bundle between the four ADC channel streams, the channel arbiter
//   and the shared high-pass FIR input port.
//   slave  : arbiter view (consumes s_axis_*, produces m_axis_*)
//   master : environment view (produces s_axis_*, consumes m_axis_*)
//   s_axis_tdata  NCH*DW  channel i in bits [i*DW +: DW]
//   s_axis_tvalid NCH     per-channel valid
//   s_axis_tready NCH     per-channel ready
//   m_axis_tdata  DW      granted sample
//   m_axis_tvalid 1       registered output valid
//   m_axis_tready 1       FIR ready
//   m_axis_tuser  2       channel index of current beat
//   m_axis_tlast  1       high on channel 3 beats
interface highpass_ch_arbiter_if #(
  parameter int DW  = 24,
  parameter int NCH = 4
);
  logic [NCH*DW-1:0] s_axis_tdata;
  logic [NCH-1:0]    s_axis_tvalid;
  logic [NCH-1:0]    s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [1:0]        m_axis_tuser;
  logic              m_axis_tlast;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast
  );
endinterface

// File: rtl/highpass_ch_arbiter.sv
// highpass_ch_arbiter
//   Four-channel scheduler in front of the shared high-pass FIR. Each channel
//   has a one-entry holding register; one held sample per beat is moved into
//   the registered output stage, tagged with its channel on tuser and with
//   tlast on channel 3. Data passes through untouched.
// Ports:
//   s_axis_aclk   clock
//   s_axis_arstn  asynchronous active-low reset
//   ch_en         per-channel enable (disabled: input swallowed, never granted)
//   axis          stream bundle (slave modport of highpass_ch_arbiter_if)
//   frame_cnt     count of accepted tlast beats, wraps at 16 bits
// Build option:
//   HIGHPASS_ARB_STRICT_ORDER_EN  strict 0..3 channel order via next_ch;
//                                 undefined = work-conserving round-robin.
module highpass_ch_arbiter #(
  parameter int DW  = 24,
  parameter int NCH = 4
) (
  input  logic                 s_axis_aclk,
  input  logic                 s_axis_arstn,
  input  logic [NCH-1:0]       ch_en,
  highpass_ch_arbiter_if.slave axis,
  output logic [15:0]          frame_cnt
);

  logic [NCH-1:0][DW-1:0] hold_d_q, hold_d_d;
  logic [NCH-1:0]         hold_v_q, hold_v_d;
  logic [NCH-1:0]         elig, take, s_rdy;
  logic [DW-1:0]          m_tdata_q, m_tdata_d;
  logic                   m_tvalid_q, m_tvalid_d;
  logic                   m_tlast_q, m_tlast_d;
  logic [1:0]             m_tuser_q, m_tuser_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic                   load, found;
  logic [1:0]             gnt;

`ifdef HIGHPASS_ARB_STRICT_ORDER_EN
  logic [1:0] next_ch_q, next_ch_d, nidx;
  logic       nfound;
`else
  logic [1:0] ptr_q, ptr_d, idx;
`endif

  // Arbitration: pick the granted channel and decide whether the output
  // register loads this cycle.
  always_comb begin : arb
    elig  = hold_v_q & ch_en;
    found = 1'b0;
    gnt   = '0;
`ifdef HIGHPASS_ARB_STRICT_ORDER_EN
    // Only the channel whose turn it is may go.
    found = elig[next_ch_q];
    gnt   = next_ch_q;
`else
    idx = '0;
    // k = 1..NCH scans ptr+1 .. ptr (wrapping), so the last winner is lowest.
    for (int k = 1; k <= NCH; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
`endif
    load = (!m_tvalid_q | axis.m_axis_tready) & found;
    take = '0;
    if (load) take[gnt] = 1'b1;
  end

  // Holding registers. Ready includes take so a channel can stream at
  // one beat per clock (combinational path from m_axis_tready).
  always_comb begin : lanes
    hold_v_d = hold_v_q;
    hold_d_d = hold_d_q;
    s_rdy    = '0;
    for (int i = 0; i < NCH; i++) begin
      s_rdy[i] = s_axis_arstn & (!ch_en[i] | !hold_v_q[i] | take[i]);
      if (!ch_en[i])
        hold_v_d[i] = 1'b0;              // disabled: drop held sample, swallow input
      else if (axis.s_axis_tvalid[i] && s_rdy[i]) begin
        hold_v_d[i] = 1'b1;              // also covers refill in the take cycle
        hold_d_d[i] = axis.s_axis_tdata[i*DW +: DW];
      end else if (take[i])
        hold_v_d[i] = 1'b0;
    end
  end

  // Output stage and frame counter.
  always_comb begin : outp
    m_tdata_d   = m_tdata_q;
    m_tvalid_d  = m_tvalid_q;
    m_tuser_d   = m_tuser_q;
    m_tlast_d   = m_tlast_q;
    frame_cnt_d = frame_cnt_q;
    if (m_tvalid_q && axis.m_axis_tready && m_tlast_q)
      frame_cnt_d = frame_cnt_q + 16'd1;
    if (load) begin
      m_tdata_d  = hold_d_q[gnt];
      m_tuser_d  = gnt;
      m_tlast_d  = (gnt == 2'd3);
      m_tvalid_d = 1'b1;
    end else if (m_tvalid_q && axis.m_axis_tready)
      m_tvalid_d = 1'b0;
  end

`ifdef HIGHPASS_ARB_STRICT_ORDER_EN
  // Turn pointer: moves on after a grant, or skips a disabled channel
  // without granting. Holds when nothing is enabled.
  always_comb begin : order
    next_ch_d = next_ch_q;
    nidx      = '0;
    nfound    = 1'b0;
    if (|ch_en && (load || !ch_en[next_ch_q])) begin
      for (int k = 1; k <= NCH; k++) begin
        nidx = next_ch_q + 2'(k);
        if (!nfound && ch_en[nidx]) begin
          nfound    = 1'b1;
          next_ch_d = nidx;
        end
      end
    end
  end
`else
  always_comb begin : order
    ptr_d = ptr_q;
    if (load) ptr_d = gnt;
  end
`endif

  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) begin
      hold_d_q    <= '0;
      hold_v_q    <= '0;
      m_tdata_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tuser_q   <= '0;
      m_tlast_q   <= 1'b0;
      frame_cnt_q <= '0;
`ifdef HIGHPASS_ARB_STRICT_ORDER_EN
      next_ch_q   <= 2'd0;
`else
      ptr_q       <= 2'd3;   // channel 0 gets first priority
`endif
    end else begin
      hold_d_q    <= hold_d_d;
      hold_v_q    <= hold_v_d;
      m_tdata_q   <= m_tdata_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tuser_q   <= m_tuser_d;
      m_tlast_q   <= m_tlast_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef HIGHPASS_ARB_STRICT_ORDER_EN
      next_ch_q   <= next_ch_d;
`else
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign axis.s_axis_tready = s_rdy;
  assign axis.m_axis_tdata  = m_tdata_q;
  assign axis.m_axis_tvalid = m_tvalid_q;
  assign axis.m_axis_tuser  = m_tuser_q;
  assign axis.m_axis_tlast  = m_tlast_q;
  assign frame_cnt          = frame_cnt_q;

endmodule

// File: tb/tb_highpass_ch_arbiter.sv
// Self-checking bench for highpass_ch_arbiter: directed scenarios with
// constant expectations plus a randomized run against a rule-level model.
module tb_highpass_ch_arbiter;
  localparam int DW  = 24;
  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ch_en = 4'hF;
  logic [15:0] frame_cnt;

  highpass_ch_arbiter_if #(.DW(DW), .NCH(NCH)) bus ();

  highpass_ch_arbiter #(.DW(DW), .NCH(NCH)) dut (
    .s_axis_aclk (clk),
    .s_axis_arstn(rst_n),
    .ch_en       (ch_en),
    .axis        (bus.slave),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // beat capture
  int          bu[$];
  logic [23:0] bd[$];
  bit          bl[$];
  int          bc[$];

  // reference model state: pending sample per channel, output slot,
  // last granted channel / channel whose turn it is, frames seen.
  bit          mp[4];
  logic [23:0] md[4];
  bit          mov;
  logic [23:0] mod_d;
  int          moch, mlast, mnxt, mframes;
  bit          mgrant;
  int          mg;
  logic [3:0]  exp_rdy;

  task automatic clear_beats();
    bu.delete(); bd.delete(); bl.delete(); bc.delete();
  endtask

  task automatic record(input int cyc);
    if (bus.m_axis_tvalid === 1'b1) begin
      bu.push_back(int'(bus.m_axis_tuser));
      bd.push_back(bus.m_axis_tdata);
      bl.push_back(bus.m_axis_tlast);
      bc.push_back(cyc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ch_en = 4'hF;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tdata  = '0;
    bus.m_axis_tready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin mp[i] = 0; md[i] = '0; end
    mov = 0; mod_d = '0; moch = 0; mlast = 3; mnxt = 0; mframes = 0;
  endtask

  task automatic model_comb();
    int c;
    mgrant = 0; mg = 0;
    if (!mov || bus.m_axis_tready) begin
`ifdef HIGHPASS_ARB_STRICT_ORDER_EN
      if (mp[mnxt] && ch_en[mnxt]) begin mgrant = 1; mg = mnxt; end
`else
      for (int k = 1; k <= 4; k++) begin
        c = (mlast + k) % 4;
        if (!mgrant && mp[c] && ch_en[c]) begin mgrant = 1; mg = c; end
      end
`endif
    end
    for (int i = 0; i < 4; i++)
      exp_rdy[i] = !ch_en[i] || !mp[i] || (mgrant && mg == i);
  endtask

  task automatic model_seq();
    int n, c;
    bit f;
    if (mov && bus.m_axis_tready && moch == 3) mframes = (mframes + 1) % 65536;
`ifdef HIGHPASS_ARB_STRICT_ORDER_EN
    n = mnxt; f = 0;
    if (ch_en != 4'h0 && (mgrant || !ch_en[mnxt])) begin
      for (int k = 1; k <= 4; k++) begin
        c = (mnxt + k) % 4;
        if (!f && ch_en[c]) begin f = 1; n = c; end
      end
    end
`else
    n = 0; c = 0; f = 0;
`endif
    if (mgrant) begin mov = 1; mod_d = md[mg]; moch = mg; mlast = mg; end
    else if (mov && bus.m_axis_tready) mov = 0;
    for (int i = 0; i < 4; i++) begin
      if (!ch_en[i]) mp[i] = 0;
      else if (bus.s_axis_tvalid[i] && exp_rdy[i]) begin
        mp[i] = 1; md[i] = bus.s_axis_tdata[i*DW +: DW];
      end else if (mgrant && mg == i) mp[i] = 0;
    end
`ifdef HIGHPASS_ARB_STRICT_ORDER_EN
    mnxt = n;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ch_en = 4'hF;
    bus.s_axis_tvalid = 4'hF;
    bus.s_axis_tdata  = '1;
    bus.m_axis_tready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", bus.m_axis_tvalid); end
    checks++; if (bus.m_axis_tdata !== 24'h0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", bus.m_axis_tdata); end
    checks++; if (bus.m_axis_tuser !== 2'd0 || bus.m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tuser_tlast: got %0d/%b expected 0/0", bus.m_axis_tuser, bus.m_axis_tlast); end
    checks++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    checks++; if (bus.s_axis_tready !== 4'h0) begin errors++; $display("FAIL reset_tready: got %b expected 0000", bus.s_axis_tready); end
    bus.s_axis_tvalid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.s_axis_tready !== 4'hF) begin errors++; $display("FAIL post_reset_tready: got %b expected 1111", bus.s_axis_tready); end
  endtask

  task automatic test_four_channels();
    do_reset();
    clear_beats();
    bus.s_axis_tvalid = 4'hF;
    bus.s_axis_tdata  = {24'h000004, 24'h000003, 24'h000002, 24'h000001};
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (cyc == 0) bus.s_axis_tvalid = '0;
      record(cyc);
    end
    checks++; if (bu.size() != 4) begin errors++; $display("FAIL four_count: got %0d beats expected 4", bu.size()); end
    for (int k = 0; k < bu.size() && k < 4; k++) begin
      checks++;
      if (bu[k] != k || bd[k] !== 24'(k + 1) || bl[k] != (k == 3) || bc[k] != k + 1) begin
        errors++;
        $display("FAIL four_beat%0d: got user %0d data %h last %b cyc %0d expected user %0d data %h last %b cyc %0d",
                 k, bu[k], bd[k], bl[k], bc[k], k, k + 1, (k == 3), k + 1);
      end
    end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL four_frame_cnt: got %0d expected 1", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    do_reset();
    clear_beats();
    for (int cyc = 0; cyc < 16; cyc++) begin
      record(cyc);
      if (sent < 10) begin
        bus.s_axis_tvalid = 4'b0100;
        bus.s_axis_tdata[2*DW +: DW] = 24'h000100 + 24'(sent);
      end else bus.s_axis_tvalid = '0;
      #1;
      if (sent < 10) begin
        checks++;
        if (bus.s_axis_tready[2] !== 1'b1) begin errors++; $display("FAIL b2b_tready2 cyc%0d: got %b expected 1", cyc, bus.s_axis_tready[2]); end
        if (bus.s_axis_tready[2] === 1'b1) sent++;
      end
      @(posedge clk); @(negedge clk);
    end
    checks++; if (bu.size() != 10) begin errors++; $display("FAIL b2b_count: got %0d beats expected 10", bu.size()); end
    for (int k = 0; k < bu.size() && k < 10; k++) begin
      checks++;
      if (bu[k] != 2 || bl[k] != 0 || bd[k] !== 24'h000100 + 24'(k) || bc[k] != bc[0] + k) begin
        errors++;
        $display("FAIL b2b_beat%0d: got user %0d last %b data %h cyc %0d expected user 2 last 0 data %h cyc %0d",
                 k, bu[k], bl[k], bd[k], bc[k], 24'h000100 + 24'(k), bc[0] + k);
      end
    end
  endtask

  task automatic test_backpressure();
    int          eu[5] = '{0, 1, 2, 3, 0};
    logic [23:0] ed[5] = '{24'h10, 24'h11, 24'h12, 24'h13, 24'h20};
    do_reset();
    bus.m_axis_tready = 1'b0;
    bus.s_axis_tvalid = 4'hF;
    bus.s_axis_tdata  = {24'h13, 24'h12, 24'h11, 24'h10};
    @(posedge clk); @(negedge clk);
    bus.s_axis_tdata  = {24'h23, 24'h22, 24'h21, 24'h20};
    @(posedge clk); @(negedge clk);
    bus.s_axis_tvalid = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 24'h10 || bus.m_axis_tuser !== 2'd0) begin
        errors++;
        $display("FAIL stall_hold cyc%0d: got v %b data %h user %0d expected v 1 data 10 user 0", c, bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tuser);
      end
      checks++;
      if (bus.s_axis_tready !== 4'h0) begin errors++; $display("FAIL stall_tready cyc%0d: got %b expected 0000", c, bus.s_axis_tready); end
      @(posedge clk); @(negedge clk);
    end
    bus.m_axis_tready = 1'b1;
    clear_beats();
    for (int cyc = 0; cyc < 8; cyc++) begin
      record(cyc);
      @(posedge clk); @(negedge clk);
    end
    checks++; if (bu.size() != 5) begin errors++; $display("FAIL drain_count: got %0d beats expected 5", bu.size()); end
    for (int k = 0; k < bu.size() && k < 5; k++) begin
      checks++;
      if (bu[k] != eu[k] || bd[k] !== ed[k]) begin
        errors++; $display("FAIL drain_beat%0d: got user %0d data %h expected user %0d data %h", k, bu[k], bd[k], eu[k], ed[k]);
      end
    end
    clear_beats();
    for (int cyc = 0; cyc < 7; cyc++) begin
      record(cyc);
      bus.s_axis_tvalid = (cyc < 2) ? 4'b0010 : 4'b0000;
      bus.s_axis_tdata[1*DW +: DW] = (cyc == 0) ? 24'h7FFFFF : 24'h800000;
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if (bu.size() != 2) begin errors++; $display("FAIL extreme_count: got %0d beats expected 2", bu.size()); end
    else begin
      checks++;
      if (bd[0] !== 24'h7FFFFF || bd[1] !== 24'h800000 || bu[0] != 1 || bu[1] != 1) begin
        errors++; $display("FAIL extreme_data: got %h/%h user %0d/%0d expected 7fffff/800000 user 1/1", bd[0], bd[1], bu[0], bu[1]);
      end
    end
  endtask

  task automatic test_disable();
    int pat[3] = '{0, 1, 3};
    do_reset();
    ch_en = 4'b1011;
    clear_beats();
    for (int cyc = 0; cyc < 30; cyc++) begin
      record(cyc);
      bus.s_axis_tvalid = 4'hF;
      for (int i = 0; i < 4; i++) bus.s_axis_tdata[i*DW +: DW] = 24'($urandom);
      #1;
      checks++;
      if (bus.s_axis_tready[2] !== 1'b1) begin errors++; $display("FAIL dis_tready2 cyc%0d: got %b expected 1", cyc, bus.s_axis_tready[2]); end
      @(posedge clk); @(negedge clk);
    end
    checks++; if (bu.size() != 28) begin errors++; $display("FAIL dis_count: got %0d beats expected 28", bu.size()); end
    for (int k = 0; k < bu.size(); k++) begin
      checks++;
      if (bu[k] != pat[k % 3]) begin errors++; $display("FAIL dis_order beat%0d: got user %0d expected %0d", k, bu[k], pat[k % 3]); end
    end
    ch_en = 4'hF;
    bus.s_axis_tvalid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.m_axis_tready = 1'b0;
    bus.s_axis_tvalid = 4'b0111;
    bus.s_axis_tdata  = {24'h33, 24'h32, 24'h31, 24'h30};
    repeat (2) begin @(posedge clk); @(negedge clk); end
    bus.s_axis_tvalid = '0;
    #1;
    checks++; if (bus.m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", bus.m_axis_tvalid); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b expected 0", bus.m_axis_tvalid); end
    checks++; if (bus.s_axis_tready !== 4'h0) begin errors++; $display("FAIL mid_tready: got %b expected 0000", bus.s_axis_tready); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.m_axis_tready = 1'b1;
    clear_beats();
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(posedge clk); @(negedge clk);
      record(cyc);
    end
    checks++; if (bu.size() != 0) begin errors++; $display("FAIL mid_stale: got %0d beats expected 0", bu.size()); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL mid_frame_cnt: got %0d expected 0", frame_cnt); end
    bus.s_axis_tvalid = 4'hF;
    bus.s_axis_tdata  = {24'h43, 24'h42, 24'h41, 24'h40};
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (cyc == 0) bus.s_axis_tvalid = '0;
      record(cyc);
    end
    checks++;
    if (bu.size() < 1) begin errors++; $display("FAIL mid_first: got 0 beats expected >=1"); end
    else if (bu[0] != 0 || bd[0] !== 24'h40) begin errors++; $display("FAIL mid_first: got user %0d data %h expected user 0 data 40", bu[0], bd[0]); end
  endtask

`ifdef HIGHPASS_ARB_STRICT_ORDER_EN
  task automatic test_strict();
    do_reset();
    clear_beats();
    bus.s_axis_tvalid = 4'b0010;
    bus.s_axis_tdata  = {24'h53, 24'h52, 24'h51, 24'h50};
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL strict_wait cyc%0d: got %b expected 0", c, bus.m_axis_tvalid); end
    end
    bus.s_axis_tvalid = 4'b1101;
    @(posedge clk); @(negedge clk);
    bus.s_axis_tvalid = '0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      record(cyc);
      @(posedge clk); @(negedge clk);
    end
    checks++; if (bu.size() != 4) begin errors++; $display("FAIL strict_count: got %0d beats expected 4", bu.size()); end
    for (int k = 0; k < bu.size() && k < 4; k++) begin
      checks++;
      if (bu[k] != k || bd[k] !== 24'h50 + 24'(k)) begin
        errors++; $display("FAIL strict_beat%0d: got user %0d data %h expected user %0d data %h", k, bu[k], bd[k], k, 24'h50 + 24'(k));
      end
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 15) == 0) ch_en = 4'($urandom);
      else if ($urandom_range(0, 11) == 0) ch_en = 4'hF;
      bus.s_axis_tvalid = 4'($urandom);
      for (int i = 0; i < 4; i++) bus.s_axis_tdata[i*DW +: DW] = 24'($urandom);
      bus.m_axis_tready = ($urandom_range(0, 3) != 0);
      #1;
      model_comb();
      checks++;
      if (bus.s_axis_tready !== exp_rdy) begin errors++; $display("FAIL rnd_tready cyc%0d: got %b expected %b", cyc, bus.s_axis_tready, exp_rdy); end
      @(posedge clk);
      model_seq();
      @(negedge clk);
      checks++;
      if (bus.m_axis_tvalid !== mov) begin errors++; $display("FAIL rnd_tvalid cyc%0d: got %b expected %b", cyc, bus.m_axis_tvalid, mov); end
      else if (mov) begin
        checks++;
        if (bus.m_axis_tdata !== mod_d || bus.m_axis_tuser !== 2'(moch) || bus.m_axis_tlast !== (moch == 3)) begin
          errors++;
          $display("FAIL rnd_beat cyc%0d: got data %h user %0d last %b expected data %h user %0d last %b",
                   cyc, bus.m_axis_tdata, bus.m_axis_tuser, bus.m_axis_tlast, mod_d, moch, (moch == 3));
        end
      end
      checks++;
      if (frame_cnt !== 16'(mframes)) begin errors++; $display("FAIL rnd_frame_cnt cyc%0d: got %0d expected %0d", cyc, frame_cnt, mframes); end
    end
  endtask

  initial begin
    bus.s_axis_tvalid = '0;
    bus.s_axis_tdata  = '0;
    bus.m_axis_tready = 1'b1;
    test_reset();
    test_four_channels();
    test_back_to_back();
    test_backpressure();
    test_disable();
    test_reset_mid();
`ifdef HIGHPASS_ARB_STRICT_ORDER_EN
    test_strict();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
